// File: rtl/fifo_controller_pkg.sv
// rtl/fifo_controller_pkg.sv - shared defaults and helpers for the FIFO controller
package fifo_controller_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 6;
    localparam int DEFAULT_ADDR_WIDTH   = 3;
    localparam int DEFAULT_ALMOST_FULL  = 6;
    localparam int DEFAULT_ALMOST_EMPTY = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_controller_if.sv
// rtl/fifo_controller_if.sv - producer/consumer and memory-side signals of the FIFO controller
interface fifo_controller_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  push, push_data, pop, mem_rdata,
        output pop_data, valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow, write_enable, write_address, mem_wdata, read_address
    );

    modport master (
        output push, push_data, pop, mem_rdata,
        input  pop_data, valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow, write_enable, write_address, mem_wdata, read_address
    );
endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping address counter with increment enable
module fifo_ptr #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Natural binary wrap gives modulo-DEPTH behaviour for free.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_controller.sv
// rtl/fifo_controller.sv - pointer/flag controller turning a read-first dual-port RAM into a FIFO
module fifo_controller
    import fifo_controller_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int ALMOST_FULL  = DEFAULT_ALMOST_FULL,
    parameter int ALMOST_EMPTY = DEFAULT_ALMOST_EMPTY
) (
    input  logic           clk,
    input  logic           rst,
    fifo_controller_if.slave bus
);

    localparam int                  DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AEMPT_CNT = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  valid;
    logic                  overflow;
    logic                  underflow;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // No empty bypass; a push at full relies on the same-cycle pop freeing the slot.
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid <= pop_ok;
            if (bus.push & ~push_ok)
                overflow <= 1'b1;
            if (bus.pop & ~pop_ok)
                underflow <= 1'b1;
        end
    end

    assign bus.count         = count;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.almost_full   = (count >= AFULL_CNT);
    assign bus.almost_empty  = (count <= AEMPT_CNT);
    assign bus.valid         = valid;
    assign bus.overflow      = overflow;
    assign bus.underflow     = underflow;
    assign bus.write_enable  = push_ok;
    assign bus.write_address = wr_ptr;
    assign bus.mem_wdata     = bus.push_data;
    assign bus.read_address  = rd_ptr;
    // The RAM output register already aligns with valid, so no extra staging.
    assign bus.pop_data      = bus.mem_rdata;

endmodule
